// File: rtl/iddr_cal_pkg.sv
// Shared types for the IDDR/IDELAYE3 tap calibration controller: FSM encoding,
// default tap width and the passing-run record.
package iddr_cal_pkg;

   localparam int DEF_TAP_BITS = 9;
   localparam int RUN_W        = DEF_TAP_BITS + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VTC_OFF,
      ST_LOAD,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_FINAL,
      ST_RELEASE
   } cal_state_e;

   typedef struct packed {
      logic [RUN_W-1:0] start;
      logic [RUN_W-1:0] len;
   } run_t;

endpackage

// File: rtl/iddr_cal_window.sv
// Sampling window: counts SAMPLE_CYCLES clocks after start and reports whether every
// q1/q2 pair matched the training pattern. valid/pass are presented on the last sample.
module iddr_cal_window #(
   parameter int   SAMPLE_CYCLES = 64,
   parameter logic EXP_Q1        = 1'b1,
   parameter logic EXP_Q2        = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic q1,
   input  logic q2,
   output logic valid,
   output logic pass
);

   localparam int CW = $clog2(SAMPLE_CYCLES + 1);

   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pass_q, pass_d;
   logic          hit;

   assign hit   = (q1 == EXP_Q1) && (q2 == EXP_Q2);
   assign valid = active_q && (cnt_q == CW'(SAMPLE_CYCLES - 1));
   // The final sample is folded in combinationally so the verdict is ready on valid.
   assign pass  = pass_q && hit;

   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      pass_d   = pass_q;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         pass_d   = 1'b1;
      end else if (active_q) begin
         pass_d = pass_q && hit;
         cnt_d  = cnt_q + 1'b1;
         if (valid) active_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         pass_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         pass_q   <= pass_d;
      end
   end

endmodule

// File: rtl/iddr_delay_cal.sv
// Per-lane IDELAY calibration: sweeps all taps, centres on the widest passing run.
// Optional define IDDR_CAL_READBACK_EN verifies the final tap via dly_cnt_value_out.
module iddr_delay_cal
   import iddr_cal_pkg::*;
#(
   parameter int   TAP_BITS      = DEF_TAP_BITS,
   parameter int   MAX_TAP       = 511,
   parameter int   SAMPLE_CYCLES = 64,
   parameter int   SETTLE_CYCLES = 8,
   parameter int   MIN_EYE       = 8,
   parameter logic EXP_Q1        = 1'b1,
   parameter logic EXP_Q2        = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                q1,
   input  logic                q2,
   input  logic [TAP_BITS-1:0] dly_cnt_value_out,
   output logic                dly_load,
   output logic [TAP_BITS-1:0] dly_cnt_value_in,
   output logic                dly_en,
   output logic                dly_inc,
   output logic                dly_en_vtc,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic [TAP_BITS-1:0] tap_center,
   output logic [TAP_BITS:0]   eye_width
);

   localparam int CNT_W  = TAP_BITS + 1;
   localparam int WAIT_W = $clog2(SETTLE_CYCLES + 2);

   cal_state_e          state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]    tap_q, tap_d;
   run_t                cur_q, cur_d, best_q, best_d, cur_v;
   logic                samp_pass_q, samp_pass_d;
   logic                ok_q, ok_d;
   logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;
   logic [TAP_BITS-1:0] center_q, center_d;
   logic [CNT_W-1:0]    width_q, width_d;
   logic                win_start, win_valid, win_pass;
   logic                settled, last_tap, eye_ok, rb_ok;
   logic [TAP_BITS-1:0] center;

   iddr_cal_window #(
      .SAMPLE_CYCLES(SAMPLE_CYCLES),
      .EXP_Q1       (EXP_Q1),
      .EXP_Q2       (EXP_Q2)
   ) u_window (
      .clk  (clk),
      .rst_n(rst_n),
      .start(win_start),
      .q1   (q1),
      .q2   (q2),
      .valid(win_valid),
      .pass (win_pass)
   );

   assign settled  = (wait_q == WAIT_W'(SETTLE_CYCLES - 1));
   assign last_tap = (tap_q == CNT_W'(MAX_TAP));
   assign eye_ok   = (best_q.len >= RUN_W'(MIN_EYE));
   assign center   = eye_ok ? (TAP_BITS'(best_q.start) + TAP_BITS'((best_q.len - RUN_W'(1)) >> 1))
                            : '0;

`ifdef IDDR_CAL_READBACK_EN
   assign rb_ok = (dly_cnt_value_out == center);
`else
   logic unused_rb;
   assign unused_rb = ^dly_cnt_value_out;
   assign rb_ok     = 1'b1;
`endif

   always_comb begin
      state_d          = state_q;
      wait_d           = wait_q;
      tap_d            = tap_q;
      cur_d            = cur_q;
      best_d           = best_q;
      cur_v            = cur_q;
      samp_pass_d      = samp_pass_q;
      ok_d             = ok_q;
      busy_d           = busy_q;
      done_d           = done_q;
      fail_d           = fail_q;
      center_d         = center_q;
      width_d          = width_q;
      win_start        = 1'b0;
      dly_load         = 1'b0;
      dly_cnt_value_in = '0;
      dly_en_vtc       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dly_en_vtc = 1'b1;
            if (start) begin
               state_d = ST_VTC_OFF;
               done_d  = 1'b0;
               fail_d  = 1'b0;
               busy_d  = 1'b1;
               tap_d   = '0;
               cur_d   = '0;
               best_d  = '0;
               wait_d  = '0;
            end
         end
         ST_VTC_OFF: begin
            wait_d = wait_q + 1'b1;
            if (settled) begin
               wait_d  = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            dly_load         = 1'b1;
            dly_cnt_value_in = tap_q[TAP_BITS-1:0];
            state_d          = ST_SETTLE;
         end
         ST_SETTLE: begin
            wait_d = wait_q + 1'b1;
            if (settled) begin
               wait_d    = '0;
               win_start = 1'b1;
               state_d   = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (win_valid) begin
               samp_pass_d = win_pass;
               state_d     = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (samp_pass_q) begin
               if (cur_v.len == '0) cur_v.start = RUN_W'(tap_q);
               cur_v.len = cur_v.len + RUN_W'(1);
            end
            // Strict compare keeps the earliest run when two are equally wide.
            if (!samp_pass_q || last_tap) begin
               if (cur_v.len > best_q.len) best_d = cur_v;
               if (!samp_pass_q) cur_v.len = '0;
            end
            cur_d = cur_v;
            if (last_tap) begin
               wait_d  = '0;
               state_d = ST_FINAL;
            end else begin
               tap_d   = tap_q + 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_FINAL: begin
            wait_d = wait_q + 1'b1;
            if (wait_q == '0) begin
               dly_load         = 1'b1;
               dly_cnt_value_in = center;
            end
            if (wait_q == WAIT_W'(SETTLE_CYCLES)) begin
               ok_d    = eye_ok && rb_ok;
               wait_d  = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            dly_en_vtc = 1'b1;
            busy_d     = 1'b0;
            done_d     = ok_q;
            fail_d     = !ok_q;
            center_d   = center;
            width_d    = CNT_W'(best_q.len);
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wait_q      <= '0;
         tap_q       <= '0;
         cur_q       <= '0;
         best_q      <= '0;
         samp_pass_q <= 1'b0;
         ok_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         center_q    <= '0;
         width_q     <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         tap_q       <= tap_d;
         cur_q       <= cur_d;
         best_q      <= best_d;
         samp_pass_q <= samp_pass_d;
         ok_q        <= ok_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         center_q    <= center_d;
         width_q     <= width_d;
      end
   end

   assign dly_en     = 1'b0;
   assign dly_inc    = 1'b0;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fail       = fail_q;
   assign tap_center = center_q;
   assign eye_width  = width_q;

endmodule
